dmem_responder: RTL

- Data-memory responder: the slave end of the load/store request channel issued by the pipeline's memory stage.
- Accepts one request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, performs a byte, half or word access on an internal word array, and returns a registered response through a valid/ready handshake.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// +-------------------------------------------------------------------------+
// | dmem_responder_if : load/store request and response channel             |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// +-------------------------------------------------------------------------+
// | dmem_responder : data-memory slave with wait states and fault flagging  |
// | Optional DMEM_STATS_EN adds load/store/error counters. Revision 1.0     |
// +-------------------------------------------------------------------------+
`default_nettype none

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]      stat_loads,
  output logic [31:0]      stat_stores,
  output logic [31:0]      stat_errs
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic [31:0]     req_offset;
  logic [AW-1:0]   req_idx;
  logic            req_err;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;

  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns,
                                           input logic zero);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = 32'd0;
    if (!zero) begin
      case (size)
        2'd0:    res = uns ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
        2'd1:    res = uns ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
        default: res = word;
      endcase
    end
    return res;
  endfunction

  assign bus.req_ready = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == S_RESP) && !reset;
  assign bus.rsp_rdata = reset ? 32'd0 : rdata_q;
  assign bus.rsp_err   = reset ? 1'b0  : rsp_err_q;

  always_comb begin
    accept     = bus.req_valid && bus.req_ready;
    // Unsigned subtraction makes addresses below the base wrap high and fault.
    req_offset = bus.req_addr - BASE_ADDR;
    req_idx    = req_offset[AW+1:2];
    req_err    = (bus.req_size == 2'd3)
              || ((bus.req_size == 2'd1) && bus.req_addr[0])
              || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00))
              || ({1'b0, req_offset} >= SPAN);

    case (bus.req_size)
      2'd0:    wr_be = 4'b0001 << bus.req_addr[1:0];
      2'd1:    wr_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
    case (bus.req_size)
      2'd0:    wr_data = {4{bus.req_wdata[7:0]}};
      2'd1:    wr_data = {2{bus.req_wdata[15:0]}};
      default: wr_data = bus.req_wdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    err_d     = err_q;
    idx_d     = idx_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d   = bus.req_we;
          off_d  = bus.req_addr[1:0];
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          err_d  = req_err;
          idx_d  = req_idx;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d   = S_RESP;
            rdata_d   = fmt_load(mem[req_idx], bus.req_addr[1:0], bus.req_size,
                                 bus.req_unsigned, bus.req_we || req_err);
            rsp_err_d = req_err;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_RESP;
          rdata_d   = fmt_load(mem[idx_q], off_q, size_q, uns_q, we_q || err_q);
          rsp_err_d = err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      off_q     <= 2'd0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Array is never cleared; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] loads_q, loads_d, stores_q, stores_d, errs_q, errs_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (accept) begin
      if (req_err) begin
        if (errs_q != 32'hFFFF_FFFF) errs_d = errs_q + 32'd1;
      end else if (bus.req_we) begin
        if (stores_q != 32'hFFFF_FFFF) stores_d = stores_q + 32'd1;
      end else begin
        if (loads_q != 32'hFFFF_FFFF) loads_d = loads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      errs_q   <= 32'd0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

`default_nettype wire
